// File: rtl/ascon_pkg.sv
// ascon_pkg: mode encoding, sequencer states and word counts shared by the ascon sequencer.
package ascon_pkg;
  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;
  localparam int KEY_WORDS = 4;
  localparam int NONCE_WORDS = 4;
  typedef enum logic [2:0] {S_IDLE, S_KEY, S_NONCE, S_ASSOC, S_DATA, S_TAG} state_t;
  // Word i of a 128-bit value, most significant word first
  function automatic logic [31:0] word_sel(input logic [127:0] v, input logic [1:0] i);
    return v[{~i, 5'd0} +: 32];
  endfunction
endpackage

// File: rtl/ascon_seq_timer.sv
// ascon_seq_timer: loadable down-counter whose expiry flag is high at zero.
module ascon_seq_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         expired
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= load ? load_val : (en && cnt != '0) ? cnt - 1'b1 : cnt;
  assign expired = cnt == '0;
endmodule

// File: rtl/ascon_seq.sv
// ascon_seq: feeds key, nonce, associated data and payload into an ascon core and collects its tag.
module ascon_seq
  import ascon_pkg::*;
#(
  parameter int TAG_TIMEOUT = 64,
  parameter int AD_LEN_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                start_ready,
  input  logic                job_mode,
  input  logic [127:0]        job_key,
  input  logic [127:0]        job_nonce,
  input  logic [AD_LEN_W-1:0] job_ad_len,
  input  logic [31:0]         ad_in,
  input  logic                ad_valid,
  output logic                ad_ready,
  input  logic [31:0]         din,
  input  logic                din_valid,
  input  logic                din_last,
  output logic                din_ready,
  output logic [31:0]         dout,
  output logic                dout_valid,
  output logic                dout_last,
  output logic [127:0]        tag_out,
  output logic                done,
  output logic                err,
  input  logic                abort,
  output logic                core_mode,
  output logic [31:0]         core_key_in,
  output logic                core_key_valid,
  input  logic                core_key_ready,
  output logic [31:0]         core_nonce_in,
  output logic                core_nonce_valid,
  input  logic                core_nonce_ready,
  output logic [31:0]         core_assoc_in,
  output logic                core_assoc_valid,
  input  logic                core_assoc_ready,
  output logic [31:0]         core_data_in,
  output logic                core_data_in_valid,
  output logic                core_data_in_last,
  input  logic                core_data_in_ready,
  input  logic [31:0]         core_data_out,
  input  logic                core_data_out_valid,
  input  logic                core_data_out_last,
  input  logic [127:0]        core_tag,
  input  logic                core_tag_valid,
  output logic                core_rst
);
  localparam int TW = $clog2(TAG_TIMEOUT + 1);
  state_t              state;
  logic [1:0]          wcnt;
  logic [AD_LEN_W-1:0] acnt, ad_len;
  logic [127:0]        key, nonce;
  logic                mode, expired;
  ascon_seq_timer #(.W(TW)) u_timer (
    .clk,
    .rst,
    .load(state != S_TAG),
    .en(state == S_TAG),
    .load_val(TW'(TAG_TIMEOUT - 1)),
    .expired
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      wcnt <= '0;
      acnt <= '0;
      mode <= MODE_ENC;
      key <= '0;
      nonce <= '0;
      ad_len <= '0;
      tag_out <= '0;
      done <= 1'b0;
      err <= 1'b0;
      core_rst <= 1'b0;
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      core_rst <= 1'b0;
      // Abort outranks every in-flight event, including a tag arriving the same cycle
      if (abort && state != S_IDLE) begin
        err <= 1'b1;
        core_rst <= 1'b1;
        state <= S_IDLE;
      end else
        case (state)
          S_IDLE: if (start) begin
            mode <= job_mode;
            key <= job_key;
            nonce <= job_nonce;
            ad_len <= job_ad_len;
            wcnt <= '0;
            acnt <= '0;
            state <= S_KEY;
          end
          S_KEY: if (core_key_ready) begin
            wcnt <= wcnt + 1'b1;
            if (wcnt == 2'(KEY_WORDS - 1)) state <= S_NONCE;
          end
          S_NONCE: if (core_nonce_ready) begin
            wcnt <= wcnt + 1'b1;
            if (wcnt == 2'(NONCE_WORDS - 1)) state <= ad_len != '0 ? S_ASSOC : S_DATA;
          end
          S_ASSOC: if (ad_valid && core_assoc_ready) begin
            acnt <= acnt + 1'b1;
            if (acnt == ad_len - 1'b1) state <= S_DATA;
          end
          S_DATA: if (din_valid && din_last && core_data_in_ready) state <= S_TAG;
          S_TAG: if (core_tag_valid) begin
            tag_out <= core_tag;
            done <= 1'b1;
            state <= S_IDLE;
          end else if (expired) begin
            err <= 1'b1;
            core_rst <= 1'b1;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
    end
  assign start_ready = state == S_IDLE;
  assign core_mode = mode;
  assign core_key_in = word_sel(key, wcnt);
  assign core_key_valid = state == S_KEY;
  assign core_nonce_in = word_sel(nonce, wcnt);
  assign core_nonce_valid = state == S_NONCE;
  assign core_assoc_in = ad_in;
  assign core_assoc_valid = state == S_ASSOC && ad_valid;
  assign ad_ready = state == S_ASSOC && core_assoc_ready;
  assign core_data_in = din;
  assign core_data_in_valid = state == S_DATA && din_valid;
  assign core_data_in_last = state == S_DATA && din_last;
  assign din_ready = state == S_DATA && core_data_in_ready;
  assign dout = core_data_out;
  assign dout_valid = core_data_out_valid;
  assign dout_last = core_data_out_last;
endmodule

// File: tb/tb_ascon_seq.sv
// tb_ascon_seq: randomized job traffic against a word-queue model of the sequencer.
module tb_ascon_seq;
  import ascon_pkg::*;
  localparam int TO = 64;
  logic clk = 1'b0, rst = 1'b1;
  logic start = 1'b0, start_ready, job_mode = 1'b0;
  logic [127:0] job_key = '0, job_nonce = '0;
  logic [7:0] job_ad_len = '0;
  logic [31:0] ad_in = '0, din = '0, dout;
  logic ad_valid = 1'b0, ad_ready, din_valid = 1'b0, din_last = 1'b0, din_ready;
  logic dout_valid, dout_last, done, err, abort = 1'b0, core_mode, core_rst;
  logic [127:0] tag_out, core_tag = '0;
  logic [31:0] core_key_in, core_nonce_in, core_assoc_in, core_data_in, core_data_out = '0;
  logic core_key_valid, core_nonce_valid, core_assoc_valid, core_data_in_valid, core_data_in_last;
  logic core_key_ready = 1'b0, core_nonce_ready = 1'b0, core_assoc_ready = 1'b0, core_data_in_ready = 1'b0;
  logic core_data_out_valid = 1'b0, core_data_out_last = 1'b0, core_tag_valid = 1'b0;
  int checks = 0, fails = 0;
  // Model: a job is just the ordered word lists the core must see; the active channel is the first non-empty list
  bit busy, exp_done, exp_err, nx_done, nx_err, saw_ad, toggle_key;
  logic mmode;
  logic [127:0] mtag, last_tag;
  int tag_cnt, ch, nk, nn, na, nd, done_n, tick;
  logic [31:0] kq[$], nq[$], aq[$], dq[$], key_log[$], adw[$], dw[$];

  ascon_seq dut (
    .clk(clk), .rst(rst), .start(start), .start_ready(start_ready), .job_mode(job_mode),
    .job_key(job_key), .job_nonce(job_nonce), .job_ad_len(job_ad_len),
    .ad_in(ad_in), .ad_valid(ad_valid), .ad_ready(ad_ready),
    .din(din), .din_valid(din_valid), .din_last(din_last), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_last(dout_last),
    .tag_out(tag_out), .done(done), .err(err), .abort(abort), .core_mode(core_mode),
    .core_key_in(core_key_in), .core_key_valid(core_key_valid), .core_key_ready(core_key_ready),
    .core_nonce_in(core_nonce_in), .core_nonce_valid(core_nonce_valid), .core_nonce_ready(core_nonce_ready),
    .core_assoc_in(core_assoc_in), .core_assoc_valid(core_assoc_valid), .core_assoc_ready(core_assoc_ready),
    .core_data_in(core_data_in), .core_data_in_valid(core_data_in_valid), .core_data_in_last(core_data_in_last),
    .core_data_in_ready(core_data_in_ready), .core_data_out(core_data_out),
    .core_data_out_valid(core_data_out_valid), .core_data_out_last(core_data_out_last),
    .core_tag(core_tag), .core_tag_valid(core_tag_valid), .core_rst(core_rst)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int chan();
    if (!busy) return 0;
    if (kq.size() != 0) return 1;
    if (nq.size() != 0) return 2;
    if (aq.size() != 0) return 3;
    if (dq.size() != 0) return 4;
    return 5;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_start_ready", 128'(start_ready), 128'(1));
      chk("rst_outputs", 128'({core_key_valid, core_nonce_valid, core_assoc_valid, core_data_in_valid,
                               ad_ready, din_ready, done, err, core_rst}), 128'(0));
      chk("rst_tag_out", tag_out, 128'(0));
      busy = 0; exp_done = 0; exp_err = 0; mtag = '0;
      kq.delete(); nq.delete(); aq.delete(); dq.delete();
    end else begin
      ch = chan();
      chk("start_ready", 128'(start_ready), 128'(!busy));
      chk("key_valid", 128'(core_key_valid), 128'(ch == 1));
      chk("nonce_valid", 128'(core_nonce_valid), 128'(ch == 2));
      chk("assoc_valid", 128'(core_assoc_valid), 128'(ch == 3 && ad_valid));
      chk("ad_ready", 128'(ad_ready), 128'(ch == 3 && core_assoc_ready));
      chk("data_valid", 128'(core_data_in_valid), 128'(ch == 4 && din_valid));
      chk("din_ready", 128'(din_ready), 128'(ch == 4 && core_data_in_ready));
      chk("dout", 128'({dout_valid, dout_last, dout}), 128'({core_data_out_valid, core_data_out_last, core_data_out}));
      chk("done", 128'(done), 128'(exp_done));
      chk("err", 128'(err), 128'(exp_err));
      chk("core_rst", 128'(core_rst), 128'(exp_err));
      chk("tag_out", tag_out, mtag);
      if (busy) chk("core_mode", 128'(core_mode), 128'(mmode));
      if (done) done_n++;
      if (ad_ready || core_assoc_valid) saw_ad = 1;
      if (ch == 1 && core_key_valid) begin
        chk("key_word", 128'(core_key_in), 128'(kq[0]));
        if (core_key_ready) begin key_log.push_back(core_key_in); void'(kq.pop_front()); nk++; end
      end
      if (ch == 2 && core_nonce_valid) begin
        chk("nonce_word", 128'(core_nonce_in), 128'(nq[0]));
        if (core_nonce_ready) begin void'(nq.pop_front()); nn++; end
      end
      if (ch == 3 && core_assoc_valid) begin
        chk("assoc_word", 128'(core_assoc_in), 128'(aq[0]));
        if (core_assoc_ready) begin void'(aq.pop_front()); na++; end
      end
      if (ch == 4 && core_data_in_valid) begin
        chk("data_word", 128'({core_data_in_last, core_data_in}), 128'({dq.size() == 1, dq[0]}));
        if (core_data_in_ready) begin void'(dq.pop_front()); nd++; end
      end
      nx_done = 0; nx_err = 0;
      if (!busy) begin
        if (start) begin busy = 1; mmode = job_mode; tag_cnt = 0; end
      end else if (abort) begin
        busy = 0; nx_err = 1;
        kq.delete(); nq.delete(); aq.delete(); dq.delete();
      end else if (ch == 5) begin
        if (core_tag_valid) begin mtag = core_tag; nx_done = 1; busy = 0; end
        else begin
          tag_cnt++;
          if (tag_cnt == TO) begin busy = 0; nx_err = 1; end
        end
      end
      exp_done = nx_done; exp_err = nx_err;
    end
  end

  // Core side: random readies (key ready optionally toggling every other cycle) and random output traffic
  initial forever begin
    @(posedge clk); #1;
    tick++;
    core_key_ready = toggle_key ? 1'(tick % 2) : 1'($urandom_range(0, 1));
    core_nonce_ready = 1'($urandom_range(0, 1));
    core_assoc_ready = 1'($urandom_range(0, 1));
    core_data_in_ready = 1'($urandom_range(0, 1));
    core_data_out = $urandom;
    core_data_out_valid = 1'($urandom_range(0, 1));
    core_data_out_last = 1'($urandom_range(0, 1));
  end

  task automatic fill(input int adn, input int dn);
    adw.delete(); dw.delete();
    for (int j = 0; j < adn; j++) adw.push_back($urandom);
    for (int j = 0; j < dn; j++) dw.push_back($urandom);
  endtask

  // kind: 0 normal, 1 tag timeout, 2 abort after abt data words, 3 abort with tag, 4 reset in NONCE
  task automatic job(input logic m, input logic [127:0] k, input logic [127:0] n, input int kind,
                     input int abt, input logic sa, input logic [127:0] tv);
    int g, i, d;
    bit hs;
    kq.delete(); nq.delete(); key_log.delete();
    for (int j = 0; j < 4; j++) begin
      kq.push_back(32'(k >> (96 - 32 * j)));
      nq.push_back(32'(n >> (96 - 32 * j)));
    end
    aq = adw; dq = dw;
    nk = 0; nn = 0; na = 0; nd = 0; done_n = 0; saw_ad = 0;
    job_mode = m; job_key = k; job_nonce = n; job_ad_len = 8'(adw.size());
    start = 1; abort = sa;
    g = 0;
    do begin @(negedge clk); hs = start_ready; @(posedge clk); #1; g++; end while (!hs && g < 20);
    start = 0; abort = 0;
    chk("start_accept", 128'(hs), 128'(1));
    if (kind == 4) begin
      g = 0;
      do begin @(negedge clk); g++; end while (!core_nonce_valid && g < 60);
      chk("nonce_reached", 128'(core_nonce_valid), 128'(1));
      #2 rst = 1;
      #1 chk("rst_mid_valids", 128'({core_key_valid, core_nonce_valid, core_assoc_valid, core_data_in_valid}), 128'(0));
      chk("rst_mid_start_ready", 128'(start_ready), 128'(1));
      chk("rst_mid_tag", tag_out, 128'(0));
      @(negedge clk); @(posedge clk); #1 rst = 0;
      last_tag = '0;
      return;
    end
    i = 0; g = 0;
    while (i < adw.size() && g < 3000) begin
      ad_in = adw[i]; ad_valid = $urandom_range(0, 3) != 0;
      @(negedge clk); hs = ad_valid && ad_ready;
      @(posedge clk); #1; if (hs) i++; g++;
    end
    ad_valid = 0;
    chk("ad_stream_bound", 128'(g < 3000), 128'(1));
    i = 0; g = 0;
    while (i < dw.size() && g < 200) begin
      if (kind == 2 && i == abt) break;
      din = dw[i]; din_last = i == dw.size() - 1; din_valid = $urandom_range(0, 3) != 0;
      @(negedge clk); hs = din_valid && din_ready;
      @(posedge clk); #1; if (hs) i++; g++;
    end
    din_valid = 0; din_last = 0;
    chk("data_stream_bound", 128'(g < 200), 128'(1));
    if (kind == 2) begin
      abort = 1;
      @(negedge clk); @(posedge clk); #1 abort = 0;
      @(negedge clk);
      chk("abort_err", 128'({err, core_rst, done}), 128'(3'b110));
      @(posedge clk); #1;
      return;
    end
    if (kind == 1) begin
      d = 0;
      do begin @(posedge clk); d++; @(negedge clk); end while (!err && d < 100);
      chk("timeout_cycles", 128'(d), 128'(TO));
      chk("timeout_outputs", 128'({core_rst, start_ready, done}), 128'(3'b110));
      @(posedge clk); #1;
      return;
    end
    d = $urandom_range(0, 4);
    repeat (d) begin @(posedge clk); #1; end
    core_tag = tv; core_tag_valid = 1; abort = kind == 3;
    @(negedge clk); @(posedge clk); #1 core_tag_valid = 0; abort = 0;
    @(negedge clk);
    if (kind == 3) begin
      chk("abort_tag_pulses", 128'({err, done}), 128'(2'b10));
      chk("abort_tag_keep", tag_out, last_tag);
    end else begin
      chk("done_pulse", 128'(done), 128'(1));
      chk("tag_capture", tag_out, tv);
      last_tag = tv;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    last_tag = '0;
    adw = '{32'h0}; dw = '{32'h6e000000, 32'h6173636f};
    job(MODE_ENC, '0, '0, 0, -1, 0, 128'h0123456789abcdeffedcba9876543210);
    @(posedge clk); #1;
    chk("basic_word_counts", 128'({8'(nk), 8'(nn), 8'(na), 8'(nd)}), 128'(32'h04040102));
    chk("basic_done_once", 128'(done_n), 128'(1));
    toggle_key = 1;
    fill(1, 1);
    job(MODE_DEC, 128'h000102030405060708090a0b0c0d0e0f, 128'h1, 0, -1, 0, 128'h5a5a);
    toggle_key = 0;
    chk("key_log_size", 128'(key_log.size()), 128'(4));
    chk("key_msw_first", 128'({key_log[0], key_log[1], key_log[2], key_log[3]}),
        128'h000102030405060708090a0b0c0d0e0f);
    fill(0, 2);
    job(MODE_ENC, {$urandom, $urandom, $urandom, $urandom}, 128'h2, 0, -1, 0, 128'h77);
    chk("no_ad_activity", 128'({saw_ad, 8'(na)}), 128'(0));
    fill(2, 2);
    job(MODE_ENC, 128'h3, 128'h4, 1, -1, 0, '0);
    fill(1, 3);
    job(MODE_DEC, 128'h5, 128'h6, 2, 1, 0, '0);
    chk("abort_no_done", 128'(done_n), 128'(0));
    fill(1, 2);
    job(MODE_ENC, 128'h7, 128'h8, 0, -1, 0, 128'hc0ffee);
    fill(0, 1);
    job(MODE_DEC, 128'h9, 128'ha, 3, -1, 0, 128'hdead);
    fill(1, 1);
    job(MODE_ENC, 128'hb, 128'hc, 0, -1, 1, 128'hbeef);
    fill(255, 1);
    job(MODE_DEC, 128'hd, 128'he, 0, -1, 0, 128'hfeed);
    chk("ad_max_count", 128'(na), 128'(255));
    for (int r = 0; r < 25; r++) begin
      fill($urandom_range(0, 3), $urandom_range(1, 4));
      job(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom},
          {$urandom, $urandom, $urandom, $urandom}, (r % 6 == 2 && dw.size() > 1) ? 2 : 0,
          1, r % 5 == 0, {$urandom, $urandom, $urandom, $urandom});
    end
    fill(1, 1);
    job(MODE_ENC, 128'hf, 128'h10, 4, -1, 0, '0);
    fill(1, 2);
    job(MODE_DEC, 128'h11, 128'h12, 0, -1, 0, 128'h1234);
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/ascon_seq.md
ASCON_SEQ -- requirements
Module: ascon_seq

Interface
REQ-001 Parameter TAG_TIMEOUT, default 64: max cycles in TAG state before abort.
REQ-002 Parameter AD_LEN_W, default 8: width of associated-data word count.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start/start_ready  input/output  1/1  job request handshake; accepted when both high.
REQ-006 job_mode  input  1  MODE_ENC or MODE_DEC, sampled on start accept.
REQ-007 job_key/job_nonce  input  128/128  sampled on start accept.
REQ-008 job_ad_len  input  AD_LEN_W  associated-data words, sampled on start accept.
REQ-009 ad_in/ad_valid/ad_ready  input/input/output  32/1/1  requester AD stream.
REQ-010 din/din_valid/din_last/din_ready  in/in/in/out  32/1/1/1  requester data stream.
REQ-011 dout/dout_valid/dout_last  output  32/1/1  core output passed through unregistered.
REQ-012 tag_out/done/err  output  128/1/1  captured tag; one-cycle completion pulse; one-cycle timeout/abort pulse.
REQ-013 abort  input  1  cancels current job.
REQ-014 core_* ports  mirror of ascon core: mode, key_in/valid/ready, nonce_in/valid/ready, assoc_in/valid/ready, data_in/valid/last/ready, data_out/valid/last, tag, tag_valid; plus core_rst output 1.

Function
REQ-015 States: IDLE, KEY, NONCE, ASSOC, DATA, TAG; IDLE->KEY on start accept.
REQ-016 start_ready high only in IDLE.
REQ-017 KEY: core_key_valid high; drive job_key[127:96], [95:64], [63:32], [31:0]; word counter advances on core_key_valid&&core_key_ready; after word 3 -> NONCE.
REQ-018 NONCE: same 4-word order from job_nonce on nonce handshake; after word 3 -> ASSOC if ad_len!=0, else DATA.
REQ-019 ASSOC: core_assoc_in=ad_in, core_assoc_valid=ad_valid, ad_ready=core_assoc_ready; count handshakes; at count==ad_len -> DATA.
REQ-020 DATA: core_data_in/valid/last = din/din_valid/din_last, din_ready=core_data_in_ready; handshake with din_last -> TAG.
REQ-021 Outside the owning state every core valid and requester ready SHALL be 0.
REQ-022 core_mode SHALL hold the sampled job_mode from accept until return to IDLE.
REQ-023 TAG: on core_tag_valid, register core tag into tag_out, pulse done next cycle, -> IDLE.
REQ-024 Timeout counter clears on TAG entry; at TAG_TIMEOUT cycles without tag_valid: pulse err, pulse core_rst one cycle, -> IDLE.
REQ-025 abort in any non-IDLE state: pulse err and core_rst one cycle, -> IDLE; abort in IDLE ignored.
REQ-026 abort simultaneous with core_tag_valid: abort wins, tag_out unchanged, no done.
REQ-027 start arriving with abort in IDLE: start accepted.
REQ-028 ad_len at max value (2^AD_LEN_W-1) SHALL be counted without wrap.
REQ-029 tag_out holds last captured tag until next successful job.

Reset
REQ-030 On rst: state IDLE, counters 0, tag_out 0, done/err/core_rst 0, all valids/readies 0 except start_ready=1.
REQ-031 rst mid-job SHALL drop all valids asynchronously; no done or err emitted.

Structure
REQ-032 Shared package ascon_pkg holds MODE_ENC/MODE_DEC encoding, state enum, KEY_WORDS=4, NONCE_WORDS=4.
REQ-033 One sub-module natural: ascon_seq_timer (loadable down-counter with expiry flag) for REQ-024.

Verification
REQ-034 Key=0, nonce=0, ad_len=1 (0x0), data 0x6e000000 then 0x6173636f last, ENC -> core sees 4 key, 4 nonce, 1 assoc, 2 data words in order; done once; tag_out==core tag.
REQ-035 ad_len=0 -> ASSOC skipped, ad_ready never high, core_assoc_valid never high.
REQ-036 Key 0x00010203_..._0c0d0e0f with core_key_ready toggling every other cycle -> words presented MSW first, each held stable until accepted.
REQ-037 Core never asserts tag_valid -> err pulse and core_rst pulse exactly 64 cycles after TAG entry; start_ready=1 next cycle.
REQ-038 abort in DATA after 1 word -> err, core_rst one cycle, no done, subsequent job completes normally.
REQ-039 rst asserted in NONCE -> all core valids 0 same cycle, start_ready=1, tag_out=0.
